// File: rtl/crc16_pkg.sv
// Shared constants, state type and final-CRC helper for the CRC-16 serial framer.
// Optional macro CRC16_XOROUT_EN: when defined the appended CRC is inverted (xorout 16'hFFFF).
package crc16_pkg;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_SEED = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    WAIT = 2'd2,
    CRC  = 2'd3
  } state_e;

  // Value that goes on the wire and into crc_out once the data bits are done.
  function automatic logic [15:0] crc16_final(input logic [15:0] lfsr);
`ifdef CRC16_XOROUT_EN
    return ~lfsr;
`else
    return lfsr;
`endif
  endfunction

endpackage

// File: rtl/crc16_frame_tx_if.sv
// Byte input handshake plus serial output bundle of the CRC-16 framer.
// master: upstream byte source and serial link; slave: the framer itself.
interface crc16_frame_tx_if;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        tx_en;
  logic        tx_bit;
  logic        tx_valid;
  logic        tx_sof;
  logic        tx_eof;
  logic        busy;
  logic [15:0] crc_out;

  modport master (
    output s_data, s_valid, s_last, tx_en,
    input  s_ready, tx_bit, tx_valid, tx_sof, tx_eof, busy, crc_out
  );

  modport slave (
    input  s_data, s_valid, s_last, tx_en,
    output s_ready, tx_bit, tx_valid, tx_sof, tx_eof, busy, crc_out
  );
endinterface

// File: rtl/crc16_ser_step.sv
// One-bit serial CRC-16 LFSR update; shared with the receive-side checker.
module crc16_ser_step
  import crc16_pkg::*;
(
  input  logic [15:0] i_lfsr,
  input  logic        i_bit,
  output logic [15:0] o_lfsr
);

  logic w_fb;

  // Feedback is the incoming bit against the register MSB.
  always_comb begin
    w_fb   = i_bit ^ i_lfsr[15];
    o_lfsr = {i_lfsr[14:0], 1'b0} ^ (w_fb ? CRC16_POLY : 16'h0000);
  end

endmodule

// File: rtl/crc16_frame_tx.sv
// Byte-to-serial framer: shifts bytes out MSB-first on tx_en strobes, then appends CRC-16.
// Optional macro CRC16_XOROUT_EN (see crc16_pkg) inverts the appended CRC and crc_out.
module crc16_frame_tx
  import crc16_pkg::*;
#(
  parameter logic [15:0] SEED       = CRC16_SEED,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  crc16_frame_tx_if.slave  io_bus
);

  state_e      r_state;
  state_e      w_state_next;
  logic [7:0]  r_shreg;
  logic        r_last;
  logic [15:0] r_lfsr;
  logic [3:0]  r_bitcnt;
  logic [15:0] r_crcsh;
  logic [7:0]  r_hold;
  logic        r_hold_last;
  logic        r_hold_full;
  logic        r_sof;
  logic [15:0] r_crc_out;

  logic        w_tx_valid;
  logic        w_ready;
  logic        w_step;
  logic        w_accept;
  logic        w_byte_end;
  logic [15:0] w_lfsr_next;

  crc16_ser_step u_step (
    .i_lfsr (r_lfsr),
    .i_bit  (r_shreg[7]),
    .o_lfsr (w_lfsr_next)
  );

  // Handshake qualifiers; s_ready is forced low while reset is asserted.
  always_comb begin
    w_step     = io_bus.tx_en & w_tx_valid;
    w_accept   = io_bus.s_valid & w_ready & rst;
    w_byte_end = w_step & (r_bitcnt == 4'd0);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = DATA;
      DATA: begin
        if (w_byte_end) begin
          if (r_last)                        w_state_next = CRC;
          else if (r_hold_full || w_accept)  w_state_next = DATA;
          else                               w_state_next = WAIT;
        end
      end
      WAIT: if (w_accept) w_state_next = DATA;
      CRC:  if (w_byte_end) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    w_tx_valid       = 1'b0;
    w_ready          = 1'b0;
    io_bus.tx_bit    = IDLE_LEVEL;
    io_bus.tx_sof    = 1'b0;
    io_bus.tx_eof    = 1'b0;
    io_bus.busy      = (r_state != IDLE);
    case (r_state)
      IDLE: w_ready = 1'b1;
      DATA: begin
        w_tx_valid    = 1'b1;
        io_bus.tx_bit = r_shreg[7];
        io_bus.tx_sof = r_sof;
        // A last byte in the shifter or hold blocks further input until IDLE.
        w_ready       = ~r_hold_full & ~r_last;
      end
      WAIT: w_ready = 1'b1;
      CRC: begin
        w_tx_valid    = 1'b1;
        io_bus.tx_bit = r_crcsh[15];
        io_bus.tx_eof = (r_bitcnt == 4'd0);
      end
      default: ;
    endcase
    io_bus.tx_valid = w_tx_valid;
    io_bus.s_ready  = w_ready & rst;
    io_bus.crc_out  = r_crc_out;
  end

  // Datapath: shifter, LFSR, bit counter, skid register and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg     <= 8'h00;
      r_last      <= 1'b0;
      r_lfsr      <= 16'h0000;
      r_bitcnt    <= 4'd0;
      r_crcsh     <= 16'h0000;
      r_hold      <= 8'h00;
      r_hold_last <= 1'b0;
      r_hold_full <= 1'b0;
      r_sof       <= 1'b0;
      r_crc_out   <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_shreg  <= io_bus.s_data;
            r_last   <= io_bus.s_last;
            r_lfsr   <= SEED;
            r_bitcnt <= 4'd7;
            r_sof    <= 1'b1;
          end
        end
        DATA: begin
          if (w_step) begin
            r_lfsr <= w_lfsr_next;
            r_sof  <= 1'b0;
            if (r_bitcnt == 4'd0) begin
              if (r_last) begin
                r_crcsh  <= crc16_final(w_lfsr_next);
                r_bitcnt <= 4'd15;
              end else if (r_hold_full) begin
                r_shreg     <= r_hold;
                r_last      <= r_hold_last;
                r_hold_full <= 1'b0;
                r_bitcnt    <= 4'd7;
              end else if (w_accept) begin
                r_shreg  <= io_bus.s_data;
                r_last   <= io_bus.s_last;
                r_bitcnt <= 4'd7;
              end
            end else begin
              r_shreg  <= {r_shreg[6:0], 1'b0};
              r_bitcnt <= r_bitcnt - 4'd1;
            end
          end
          // At a byte boundary an accepted byte bypasses the skid register.
          if (w_accept && !w_byte_end) begin
            r_hold      <= io_bus.s_data;
            r_hold_last <= io_bus.s_last;
            r_hold_full <= 1'b1;
          end
        end
        WAIT: begin
          if (w_accept) begin
            r_shreg  <= io_bus.s_data;
            r_last   <= io_bus.s_last;
            r_bitcnt <= 4'd7;
          end
        end
        CRC: begin
          if (w_step) begin
            r_crcsh  <= {r_crcsh[14:0], 1'b0};
            r_bitcnt <= r_bitcnt - 4'd1;
            if (r_bitcnt == 4'd0) r_crc_out <= crc16_final(r_lfsr);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_crc16_frame_tx.sv
// Directed bench for crc16_frame_tx: check vector "123456789", single zero byte, random
// tx_en, input underrun and reset during the CRC tail. Honours CRC16_XOROUT_EN.
module tb_crc16_frame_tx;

`ifdef CRC16_XOROUT_EN
  localparam logic [15:0] ExpStd  = 16'hD64E;
  localparam logic [15:0] ExpZero = 16'h1E0F;
`else
  localparam logic [15:0] ExpStd  = 16'h29B1;
  localparam logic [15:0] ExpZero = 16'hE1F0;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  logic [7:0] fb [0:15];
  int         nb;

  crc16_frame_tx_if bus ();

  crc16_frame_tx #(
    .SEED       (16'hFFFF),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_digits();
    for (int i = 0; i < 9; i++) fb[i] = 8'h31 + 8'(i);
    nb = 9;
  endtask

  task automatic load_zero();
    fb[0] = 8'h00;
    nb = 1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " s_ready"},  16'(bus.s_ready),  16'h0);
    chk({tag, " tx_valid"}, 16'(bus.tx_valid), 16'h0);
    chk({tag, " tx_sof"},   16'(bus.tx_sof),   16'h0);
    chk({tag, " tx_eof"},   16'(bus.tx_eof),   16'h0);
    chk({tag, " busy"},     16'(bus.busy),     16'h0);
    chk({tag, " tx_bit"},   16'(bus.tx_bit),   16'h1);
    chk({tag, " crc_out"},  bus.crc_out,       16'h0000);
  endtask

  // Cycle loop starting at a negedge: drive, sample, check consumed bits, advance.
  // stop_bits != 0 ends the frame early after that many consumed bits.
  task automatic run_frame(input string tag, input int gap_len, input bit rand_en,
                           input int stop_bits, input logic [15:0] exp_crc);
    int   in_idx    = 0;
    int   bit_idx   = 0;
    int   gap_cnt   = 0;
    int   cyc       = 0;
    int   stall_cnt = 0;
    bit   done      = 1'b0;
    bit   prev_hold = 1'b0;
    logic prev_bit  = 1'b0;
    logic exp_b;
    int   total;
    total = nb * 8 + 16;
    while (!done && cyc < 3000) begin
      if (in_idx < nb && !(in_idx == 3 && gap_cnt < gap_len)) begin
        bus.s_valid = 1'b1;
        bus.s_data  = fb[in_idx];
        bus.s_last  = (in_idx == nb - 1);
      end else begin
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.s_last  = 1'b0;
        if (in_idx == 3 && gap_cnt < gap_len) gap_cnt++;
      end
      bus.tx_en = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (prev_hold && bus.tx_valid) chk({tag, " hold"}, 16'(bus.tx_bit), 16'(prev_bit));
      if (bus.busy && !bus.tx_valid) stall_cnt++;
      if (bus.tx_valid && bus.tx_en) begin
        if (bit_idx < nb * 8) exp_b = fb[bit_idx / 8][7 - (bit_idx % 8)];
        else                  exp_b = exp_crc[15 - (bit_idx - nb * 8)];
        chk($sformatf("%s bit%0d bit/sof/eof", tag, bit_idx),
            16'({bus.tx_bit, bus.tx_sof, bus.tx_eof}),
            16'({exp_b, bit_idx == 0, bit_idx == total - 1}));
        bit_idx++;
        if (bit_idx == total || (stop_bits != 0 && bit_idx == stop_bits)) done = 1'b1;
      end
      prev_hold = bus.tx_valid && !bus.tx_en;
      prev_bit  = bus.tx_bit;
      if (bus.s_valid && bus.s_ready) in_idx++;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.tx_en   = 1'b0;
    chk({tag, " completed in budget"}, 16'(done), 16'h1);
    if (stop_bits == 0) begin
      chk({tag, " crc_out"}, bus.crc_out, exp_crc);
      chk({tag, " busy after eof"}, 16'(bus.busy), 16'h0);
      chk({tag, " s_ready idle"}, 16'(bus.s_ready), 16'h1);
      chk({tag, " bytes accepted"}, 16'(in_idx), 16'(nb));
    end
    if (gap_len > 0) chk({tag, " underrun seen"}, 16'(stall_cnt > 0), 16'h1);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst         = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.tx_en   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("idle s_ready", 16'(bus.s_ready), 16'h1);

    load_digits();
    run_frame("digits", 0, 1'b0, 0, ExpStd);

    load_zero();
    run_frame("zero b2b", 0, 1'b0, 0, ExpZero);

    load_digits();
    run_frame("digits rand_en", 0, 1'b1, 0, ExpStd);

    load_digits();
    run_frame("digits gap", 20, 1'b0, 0, ExpStd);

    // Abort a frame in its CRC tail; crc_out must clear.
    load_digits();
    run_frame("abort", 0, 1'b0, 75, ExpStd);
    chk("abort in crc busy", 16'(bus.busy), 16'h1);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("mid-crc reset");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    load_zero();
    run_frame("zero after reset", 0, 1'b0, 0, ExpZero);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
